// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default opcode constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    FETCH_VAL,
    DECODE,
    ISSUE,
    HALT
  } fetch_state_t;
  localparam logic [7:0] DEFAULT_HALT_OP = 8'hFF;
endpackage

// File: rtl/ir_com.sv
// ir_com: two-byte instruction register, upper byte holds the opcode and lower byte the operand
module ir_com (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_upper,
  input  logic       load_lower,
  input  logic [7:0] data_in,
  output logic [7:0] upper_q,
  output logic [7:0] lower_q
);
  // capture the memory byte into whichever half is being loaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upper_q <= 8'h00;
      lower_q <= 8'h00;
    end else begin
      if (load_upper) upper_q <= data_in;
      if (load_lower) lower_q <= data_in;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: two-byte instruction fetch sequencer with PC, memory handshake and execute hand-off
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]       HALT_OP  = DEFAULT_HALT_OP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        data_in,
  output logic [7:0]        opcode,
  output logic [7:0]        value,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load_upper, load_lower;
  logic              ir_rst;

  assign ir_rst   = !reset;
  assign mem_addr = pc_q;
  assign pc       = pc_q;

  ir_com u_ir (
    .clk       (clk),
    .rst       (ir_rst),
    .load_upper(load_upper),
    .load_lower(load_lower),
    .data_in   (data_in),
    .upper_q   (opcode),
    .lower_q   (value)
  );

  // state and program counter registers, cleared immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // next-state, PC update and the one-hot byte load strobes
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_rd      = 1'b0;
    load_upper  = 1'b0;
    load_lower  = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      IDLE: state_d = start ? FETCH_OP : IDLE;
      FETCH_OP: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          load_upper = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = FETCH_VAL;
        end
      end
      FETCH_VAL: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          load_lower = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = DECODE;
        end
      end
      DECODE: state_d = (opcode == HALT_OP) ? HALT : ISSUE;
      ISSUE: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          pc_d    = branch_en ? branch_addr : pc_q;
          state_d = FETCH_OP;
        end
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end
endmodule
